// File: rtl/nios_fprint_mutex_bank.sv
// Bank of NUM_MUTEX hardware mutexes behind a single Avalon-MM slave.
// Each channel holds an owner/value pair, an optional lease timer that frees
// an unrenewed lock, a saturating contention counter and a maskable
// release interrupt. Register map per channel: 0 MUTEX, 1 RESET_FLAG,
// 2 STATUS (W1C), 3 CTRL.
module nios_fprint_mutex_bank #(
    parameter int unsigned NUM_MUTEX    = 4,
    parameter int unsigned LEASE_CYCLES = 0,
    parameter int unsigned LEASE_W      = 24,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                                                   clk,
    input  logic                                                   reset,
    input  logic [((NUM_MUTEX > 1) ? $clog2(NUM_MUTEX) : 1) + 1:0] address,
    input  logic                                                   chipselect,
    input  logic                                                   read,
    input  logic                                                   write,
    input  logic [31:0]                                            data_from_cpu,
    output logic [31:0]                                            data_to_cpu,
    output logic                                                   irq
);

    localparam int unsigned CH_BITS = (NUM_MUTEX > 1) ? $clog2(NUM_MUTEX) : 1;

    logic [CH_BITS-1:0] ch_sel;
    logic [1:0]         reg_sel;
    logic               wr_en;
    logic               rd_en;

    logic [15:0]        owner_q      [NUM_MUTEX];
    logic [15:0]        owner_d      [NUM_MUTEX];
    logic [15:0]        value_q      [NUM_MUTEX];
    logic [15:0]        value_d      [NUM_MUTEX];
    logic [LEASE_W-1:0] lease_q      [NUM_MUTEX];
    logic [LEASE_W-1:0] lease_d      [NUM_MUTEX];
    logic [CNT_W-1:0]   cnt_q        [NUM_MUTEX];
    logic [CNT_W-1:0]   cnt_d        [NUM_MUTEX];
    logic               timed_out_q  [NUM_MUTEX];
    logic               timed_out_d  [NUM_MUTEX];
    logic               rel_pend_q   [NUM_MUTEX];
    logic               rel_pend_d   [NUM_MUTEX];
    logic               irq_en_q     [NUM_MUTEX];
    logic               irq_en_d     [NUM_MUTEX];
    logic               reset_flag_q [NUM_MUTEX];
    logic               reset_flag_d [NUM_MUTEX];

    logic [31:0]        data_q;
    logic [31:0]        rdata_d;
    logic               irq_q;
    logic               irq_d;

    assign ch_sel      = address[CH_BITS+1:2];
    assign reg_sel     = address[1:0];
    assign wr_en       = chipselect & write;
    assign rd_en       = chipselect & read;
    assign data_to_cpu = data_q;
    assign irq         = irq_q;

    // Per-channel next state: lock arbitration, lease expiry, flags and counters.
    // Clears are applied before sets so that a same-cycle set always wins.
    always_comb begin
        irq_d = 1'b0;
        for (int unsigned i = 0; i < NUM_MUTEX; i++) begin
            logic hit;
            logic held;
            logic mutex_wr;
            logic accept;
            logic reject;
            logic expire;

            owner_d[i]      = owner_q[i];
            value_d[i]      = value_q[i];
            lease_d[i]      = lease_q[i];
            cnt_d[i]        = cnt_q[i];
            timed_out_d[i]  = timed_out_q[i];
            rel_pend_d[i]   = rel_pend_q[i];
            irq_en_d[i]     = irq_en_q[i];
            reset_flag_d[i] = reset_flag_q[i];

            hit      = wr_en && (ch_sel == CH_BITS'(i));
            held     = (value_q[i] != 16'h0);
            mutex_wr = hit && (reg_sel == 2'd0);
            accept   = mutex_wr && (!held || (owner_q[i] == data_from_cpu[31:16]));
            reject   = mutex_wr && !accept;
            expire   = (LEASE_CYCLES != 0) && held && !accept &&
                       (lease_q[i] == LEASE_W'(LEASE_CYCLES - 1));

            if (accept) begin
                owner_d[i] = data_from_cpu[31:16];
                value_d[i] = data_from_cpu[15:0];
            end else if (expire) begin
                owner_d[i] = '0;
                value_d[i] = '0;
            end

            if (LEASE_CYCLES == 0 || accept || !held || expire)
                lease_d[i] = '0;
            else
                lease_d[i] = lease_q[i] + 1'b1;

            if (hit && reg_sel == 2'd1)
                reset_flag_d[i] = 1'b0;

            if (hit && reg_sel == 2'd2) begin
                if (data_from_cpu[1]) timed_out_d[i] = 1'b0;
                if (data_from_cpu[2]) rel_pend_d[i]  = 1'b0;
                if (data_from_cpu[3]) cnt_d[i]       = '0;
            end

            if (hit && reg_sel == 2'd3)
                irq_en_d[i] = data_from_cpu[0];

            if (expire)
                timed_out_d[i] = 1'b1;
            if (held && ((accept && data_from_cpu[15:0] == 16'h0) || expire))
                rel_pend_d[i] = 1'b1;
            if (reject && cnt_d[i] != '1)
                cnt_d[i] = cnt_d[i] + 1'b1;

            irq_d = irq_d | (rel_pend_q[i] & irq_en_q[i]);
        end
    end

    // Read mux over pre-edge state; channels beyond NUM_MUTEX read as zero.
    always_comb begin
        rdata_d = '0;
        for (int unsigned i = 0; i < NUM_MUTEX; i++) begin
            if (ch_sel == CH_BITS'(i)) begin
                case (reg_sel)
                    2'd0:    rdata_d = {owner_q[i], value_q[i]};
                    2'd1:    rdata_d = {31'b0, reset_flag_q[i]};
                    2'd2:    rdata_d = {16'(cnt_q[i]), 13'b0, rel_pend_q[i],
                                        timed_out_q[i], (value_q[i] != 16'h0)};
                    default: rdata_d = {31'b0, irq_en_q[i]};
                endcase
            end
        end
    end

    // State registers, read data and interrupt output.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            irq_q  <= 1'b0;
            for (int unsigned i = 0; i < NUM_MUTEX; i++) begin
                owner_q[i]      <= '0;
                value_q[i]      <= '0;
                lease_q[i]      <= '0;
                cnt_q[i]        <= '0;
                timed_out_q[i]  <= 1'b0;
                rel_pend_q[i]   <= 1'b0;
                irq_en_q[i]     <= 1'b0;
                reset_flag_q[i] <= 1'b1;
            end
        end else begin
            if (rd_en)
                data_q <= rdata_d;
            irq_q <= irq_d;
            for (int unsigned i = 0; i < NUM_MUTEX; i++) begin
                owner_q[i]      <= owner_d[i];
                value_q[i]      <= value_d[i];
                lease_q[i]      <= lease_d[i];
                cnt_q[i]        <= cnt_d[i];
                timed_out_q[i]  <= timed_out_d[i];
                rel_pend_q[i]   <= rel_pend_d[i];
                irq_en_q[i]     <= irq_en_d[i];
                reset_flag_q[i] <= reset_flag_d[i];
            end
        end
    end

endmodule

// File: tb/tb_nios_fprint_mutex_bank.sv
// Bench for nios_fprint_mutex_bank: instance 0 uses no lease and 4 channels,
// instance 1 uses an 8-cycle lease and 3 channels (channel 3 out of range).
module tb_nios_fprint_mutex_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs    [2];
    logic        rd    [2];
    logic        wr    [2];
    logic [3:0]  addr  [2];
    logic [31:0] wd    [2];
    logic [31:0] rdata [2];
    logic        irqs  [2];

    logic [31:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    nios_fprint_mutex_bank #(
        .NUM_MUTEX(4), .LEASE_CYCLES(0), .LEASE_W(24), .CNT_W(16)
    ) u_dut (
        .clk(clk), .reset(rst), .address(addr[0]), .chipselect(cs[0]),
        .read(rd[0]), .write(wr[0]), .data_from_cpu(wd[0]),
        .data_to_cpu(rdata[0]), .irq(irqs[0])
    );

    nios_fprint_mutex_bank #(
        .NUM_MUTEX(3), .LEASE_CYCLES(8), .LEASE_W(24), .CNT_W(16)
    ) u_lease (
        .clk(clk), .reset(rst), .address(addr[1]), .chipselect(cs[1]),
        .read(rd[1]), .write(wr[1]), .data_from_cpu(wd[1]),
        .data_to_cpu(rdata[1]), .irq(irqs[1])
    );

    task automatic bus_wr(input int s, input int ch, input int rg, input logic [31:0] d);
        @(negedge clk);
        cs[s] = 1'b1; wr[s] = 1'b1; rd[s] = 1'b0;
        addr[s] = {2'(ch), 2'(rg)}; wd[s] = d;
        @(posedge clk); #1;
        cs[s] = 1'b0; wr[s] = 1'b0;
    endtask

    // Issues a read, records the expected result and returns what the DUT produced.
    task automatic bus_rd(input int s, input int ch, input int rg, input logic [31:0] e,
                          output logic [31:0] got);
        @(negedge clk);
        cs[s] = 1'b1; rd[s] = 1'b1; wr[s] = 1'b0;
        addr[s] = {2'(ch), 2'(rg)};
        exp_q.push_back(e);
        @(posedge clk); #1;
        got = rdata[s];
        cs[s] = 1'b0; rd[s] = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [31:0] got, e;
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            cs[s] = 1'b0; rd[s] = 1'b0; wr[s] = 1'b0; addr[s] = '0; wd[s] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rdata[0] !== 32'h0 || irqs[0] !== 1'b0) begin
            errors++; $display("FAIL reset_outputs got %h/%b want 0/0", rdata[0], irqs[0]);
        end
        rst = 1'b0;
        bus_rd(0, 0, 1, 32'h1, got); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL rst_flag_ch0 got %h want %h", got, e); end
        bus_rd(0, 0, 0, 32'h0, got); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL rst_mutex_ch0 got %h want %h", got, e); end
        bus_rd(0, 0, 2, 32'h0, got); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL rst_status_ch0 got %h want %h", got, e); end
        bus_wr(0, 0, 1, 32'h0);
        bus_rd(0, 0, 1, 32'h0, got); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL rst_flag_clr got %h want %h", got, e); end
        bus_rd(0, 1, 1, 32'h1, got); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL rst_flag_ch1 got %h want %h", got, e); end
    endtask

    task automatic test_contention();
        logic [31:0] got, e;
        bus_wr(0, 2, 0, 32'h0001_0005);
        bus_rd(0, 2, 0, 32'h0001_0005, got); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL acquire got %h want %h", got, e); end
        tick();
        checks++;
        if (rdata[0] !== 32'h0001_0005) begin
            errors++; $display("FAIL read_hold got %h want %h", rdata[0], 32'h0001_0005);
        end
        bus_wr(0, 2, 0, 32'h0002_0007);
        bus_rd(0, 2, 0, 32'h0001_0005, got); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL foreign_reject got %h want %h", got, e); end
        bus_rd(0, 2, 2, 32'h0001_0001, got); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL contention_1 got %h want %h", got, e); end
        bus_wr(0, 2, 0, 32'h0001_0000);
        bus_rd(0, 2, 2, 32'h0001_0004, got); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL release_status got %h want %h", got, e); end
        bus_rd(0, 2, 0, 32'h0001_0000, got); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL release_mutex got %h want %h", got, e); end
        bus_wr(0, 2, 2, 32'h0000_000C);
        bus_rd(0, 2, 2, 32'h0, got); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL w1c_status got %h want %h", got, e); end
    endtask

    task automatic test_lease();
        logic [31:0] got, e;
        bus_wr(1, 0, 0, 32'h0003_0001);
        for (int k = 1; k <= 9; k++) begin
            bus_rd(1, 0, 0, (k <= 8) ? 32'h0003_0001 : 32'h0, got);
            e = exp_q.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL lease_k%0d got %h want %h", k, got, e); end
        end
        bus_rd(1, 0, 2, 32'h6, got); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL lease_status got %h want %h", got, e); end
        bus_wr(1, 0, 2, 32'hE);
        bus_wr(1, 0, 0, 32'h0003_0001);
        for (int k = 1; k <= 4; k++) begin
            bus_rd(1, 0, 0, 32'h0003_0001, got); e = exp_q.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL renew_pre_k%0d got %h want %h", k, got, e); end
        end
        bus_wr(1, 0, 0, 32'h0003_0001);
        for (int k = 6; k <= 14; k++) begin
            bus_rd(1, 0, 0, (k <= 13) ? 32'h0003_0001 : 32'h0, got);
            e = exp_q.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL renew_k%0d got %h want %h", k, got, e); end
        end
    endtask

    task automatic test_expiry_collision();
        logic [31:0] got, e;
        bus_wr(1, 1, 0, 32'h0004_0001);
        for (int k = 1; k <= 7; k++) begin
            bus_rd(1, 1, 0, 32'h0004_0001, got); e = exp_q.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL coll_pre_k%0d got %h want %h", k, got, e); end
        end
        bus_wr(1, 1, 0, 32'h0004_0002);
        for (int k = 9; k <= 15; k++) begin
            bus_rd(1, 1, 0, 32'h0004_0002, got); e = exp_q.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL owner_renew_k%0d got %h want %h", k, got, e); end
        end
        bus_wr(1, 1, 0, 32'h0006_0001);
        bus_rd(1, 1, 0, 32'h0, got); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL foreign_expiry got %h want %h", got, e); end
        bus_rd(1, 1, 2, 32'h0001_0006, got); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL foreign_expiry_status got %h want %h", got, e); end
    endtask

    task automatic test_irq();
        logic [31:0] got, e;
        bus_wr(0, 3, 3, 32'h1);
        bus_wr(0, 3, 0, 32'h0009_0003);
        bus_wr(0, 3, 0, 32'h0009_0000);
        checks++;
        if (irqs[0] !== 1'b0) begin errors++; $display("FAIL irq_early got %b want 0", irqs[0]); end
        tick();
        checks++;
        if (irqs[0] !== 1'b1) begin errors++; $display("FAIL irq_set got %b want 1", irqs[0]); end
        bus_wr(0, 3, 2, 32'h4);
        tick();
        checks++;
        if (irqs[0] !== 1'b0) begin errors++; $display("FAIL irq_clear got %b want 0", irqs[0]); end
        bus_rd(0, 3, 3, 32'h1, got); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL ctrl_read got %h want %h", got, e); end
        // Timeout release on the same edge as a W1C of rel_pend/timed_out.
        bus_wr(1, 2, 3, 32'h1);
        bus_wr(1, 2, 0, 32'h0005_0001);
        bus_wr(1, 2, 0, 32'h0005_0000);
        tick();
        checks++;
        if (irqs[1] !== 1'b1) begin errors++; $display("FAIL lease_irq_set got %b want 1", irqs[1]); end
        bus_wr(1, 2, 0, 32'h0005_0001);
        repeat (7) tick();
        bus_wr(1, 2, 2, 32'h6);
        tick();
        checks++;
        if (irqs[1] !== 1'b1) begin errors++; $display("FAIL set_beats_clear_irq got %b want 1", irqs[1]); end
        bus_rd(1, 2, 2, 32'h6, got); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL set_beats_clear got %h want %h", got, e); end
        bus_wr(1, 3, 0, 32'h0001_0001);
        bus_rd(1, 3, 0, 32'h0, got); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL bad_ch_mutex got %h want %h", got, e); end
        bus_rd(1, 3, 1, 32'h0, got); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL bad_ch_flag got %h want %h", got, e); end
    endtask

    task automatic test_saturate_and_reset();
        logic [31:0] got, e;
        bus_wr(0, 0, 0, 32'h0001_0001);
        @(negedge clk);
        cs[0] = 1'b1; wr[0] = 1'b1; addr[0] = {2'd0, 2'd0}; wd[0] = 32'h0002_0001;
        repeat (65535) @(posedge clk);
        #1;
        cs[0] = 1'b0; wr[0] = 1'b0;
        bus_rd(0, 0, 2, 32'hFFFF_0001, got); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL cnt_max got %h want %h", got, e); end
        bus_wr(0, 0, 0, 32'h0002_0001);
        bus_rd(0, 0, 2, 32'hFFFF_0001, got); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL cnt_saturate got %h want %h", got, e); end
        bus_wr(0, 1, 3, 32'h1);
        bus_wr(0, 1, 0, 32'h0003_0001);
        bus_wr(0, 1, 0, 32'h0003_0000);
        tick();
        checks++;
        if (irqs[0] !== 1'b1) begin errors++; $display("FAIL pre_reset_irq got %b want 1", irqs[0]); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (rdata[0] !== 32'h0 || irqs[0] !== 1'b0) begin
            errors++; $display("FAIL mid_reset_outputs got %h/%b want 0/0", rdata[0], irqs[0]);
        end
        bus_rd(0, 0, 0, 32'h0, got); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL mid_reset_mutex got %h want %h", got, e); end
        bus_rd(0, 0, 1, 32'h1, got); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL mid_reset_flag got %h want %h", got, e); end
        bus_rd(0, 0, 2, 32'h0, got); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL mid_reset_status got %h want %h", got, e); end
        bus_rd(0, 1, 2, 32'h0, got); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL mid_reset_relpend got %h want %h", got, e); end
        bus_rd(0, 1, 3, 32'h0, got); e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL mid_reset_ctrl got %h want %h", got, e); end
        tick();
        checks++;
        if (irqs[0] !== 1'b0) begin errors++; $display("FAIL post_reset_irq got %b want 0", irqs[0]); end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_lease();
        test_expiry_collision();
        test_irq();
        test_saturate_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
